// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RISC-V core.
// Holds the PC, issues one word fetch at a time to instruction memory and
// writes each returned word into the IF/ID register that feeds decode.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req, imem_addr       fetch strobe (one cycle per fetch) and address (= PC)
//   imem_rvalid, imem_rdata   returned instruction word
//   stall                     decode back-pressure; IF/ID holds its contents
//   redirect_valid/_pc        taken branch/jump from execute; flush and refetch
//   id_valid, id_instr,
//   id_pc, id_pc_plus4        IF/ID register outputs
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;     // outstanding request was overtaken by a redirect
    logic [31:0] r_buf;      // word that arrived while decode was stalled
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redir_pc;
    logic        w_load;
    logic [31:0] w_load_data;

    assign w_pc_plus4 = r_pc + 32'd4;          // wraps modulo 2^32
    assign w_redir_pc = redirect_pc & ~32'h3;  // word-align the target

    // A new instruction enters IF/ID either straight from memory or from the
    // holding buffer; a redirect in the same cycle always wins.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = imem_rdata;
        if (!redirect_valid && !stall) begin
            if (r_state == S_WAIT && imem_rvalid && !r_kill) begin
                w_load = 1'b1;
            end else if (r_state == S_HOLD) begin
                w_load      = 1'b1;
                w_load_data = r_buf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_buf         <= NOP_INSTR;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 32'h0;
            r_id_pc_plus4 <= 32'h0;
        end else if (redirect_valid) begin
            // Flush IF/ID even under stall; the buffer is dropped implicitly
            // by leaving HOLD.
            r_pc       <= w_redir_pc;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            if (r_state == S_WAIT && !imem_rvalid) begin
                r_kill <= 1'b1;          // stay in WAIT until the stale word drains
            end else begin
                r_kill  <= 1'b0;
                r_state <= S_FETCH;
            end
        end else if (w_load) begin
            r_id_valid    <= 1'b1;
            r_id_instr    <= w_load_data;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
            r_pc          <= w_pc_plus4;
            r_state       <= S_FETCH;
        end else begin
            if (!stall) begin
                r_id_valid <= 1'b0;      // nothing new: insert a bubble
            end
            case (r_state)
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_FETCH;
                        end else begin
                            // Only reached with stall=1 (else w_load).
                            r_buf   <= imem_rdata;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD:  r_state <= S_HOLD;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH) && !rst;
    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory model answers
// fetches, a scoreboard of expected PCs is filled by the directed steps and
// drained whenever a fresh instruction appears in IF/ID.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'hDEAD_BEEF;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    // Second instance reset near the top of memory, shadowing the same inputs,
    // for the wrap-around checks.
    logic        d2_req, d2_valid;
    logic [31:0] d2_addr, d2_instr, d2_pc, d2_pc_plus4;

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 1;
    int m_cnt   = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] sb[$];
    logic stall_last = 1'b0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(d2_valid), .id_instr(d2_instr), .id_pc(d2_pc), .id_pc_plus4(d2_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0010_0093 + (a << 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: a request seen in cycle t returns its word during cycle t+lat.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(m_addr);
            end
        end
        if (imem_req === 1'b1) begin
            m_cnt  = lat;
            m_addr = imem_addr;
        end
    end

    // A valid IF/ID after a non-stalled cycle is a freshly loaded instruction.
    always @(negedge clk) begin
        if (id_valid === 1'b1 && !stall_last) begin
            if (sb.size() == 0) begin
                n_total++;
                $error("FAIL sb_extra: observed pc %h expected no instruction", id_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("sb_pc", id_pc, e);
                check("sb_instr", id_instr, memf(e));
                check("sb_pc_plus4", id_pc_plus4, e + 32'd4);
            end
        end
        stall_last = stall;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'h0, id_valid}, 32'h0);
        check("rst_instr", id_instr, NOP);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc_plus4, 32'h0);
        check("rst_d2_addr", d2_addr, 32'hFFFF_FFFC);

        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        rst = 1'b0; #1;                                   // C0
        check("c0_req", {31'h0, imem_req}, 32'h1);
        check("c0_addr", imem_addr, 32'h0);
        tick();                                           // C1
        check("c1_req", {31'h0, imem_req}, 32'h0);
        tick();                                           // C2
        check("c2_valid", {31'h0, id_valid}, 32'h1);
        check("c2_instr", id_instr, 32'h0010_0093);
        check("c2_addr", imem_addr, 32'h4);
        check("d2_pc", d2_pc, 32'hFFFF_FFFC);
        check("d2_pc4_wrap", d2_pc_plus4, 32'h0);
        check("d2_addr_wrap", d2_addr, 32'h0);
        tick(); tick();                                   // C4
        check("c4_addr", imem_addr, 32'h8);
        tick();                                           // C5: word for 8 arrives
        stall = 1'b1;
        tick();                                           // C6
        check("stall_valid", {31'h0, id_valid}, 32'h0);
        check("stall_pc", id_pc, 32'h4);
        check("stall_instr", id_instr, memf(32'h4));
        check("stall_req", {31'h0, imem_req}, 32'h0);
        tick(); tick();                                   // C8
        stall = 1'b0; lat = 3;
        tick();                                           // C9
        check("unstall_pc", id_pc, 32'h8);
        check("unstall_addr", imem_addr, 32'hC);
        tick();                                           // C10: WAIT
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();                                           // C11
        redirect_valid = 1'b0;
        sb.push_back(32'h100);
        check("redir_valid", {31'h0, id_valid}, 32'h0);
        check("redir_instr", id_instr, NOP);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_req_wait", {31'h0, imem_req}, 32'h0);
        tick();                                           // C12: stale word
        check("kill_req", {31'h0, imem_req}, 32'h0);
        tick();                                           // C13
        check("refetch_req", {31'h0, imem_req}, 32'h1);
        check("refetch_addr", imem_addr, 32'h100);
        tick(); tick(); tick();                           // C16
        check("kill_bubble", {31'h0, id_valid}, 32'h0);
        tick();                                           // C17
        check("redir_load_pc", id_pc, 32'h100);
        stall = 1'b1;
        tick();                                           // C18
        check("pre_flush_valid", {31'h0, id_valid}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();                                           // C19
        redirect_valid = 1'b0; stall = 1'b0;
        sb.push_back(32'h200);
        check("flush_stall_valid", {31'h0, id_valid}, 32'h0);
        check("flush_stall_instr", id_instr, NOP);
        tick(); tick();                                   // C21
        check("c21_req", {31'h0, imem_req}, 32'h1);
        check("c21_addr", imem_addr, 32'h200);
        tick(); tick(); tick(); tick();                   // C25
        check("c25_pc", id_pc, 32'h200);
        check("c25_addr", imem_addr, 32'h204);
        tick();                                           // C26: WAIT
        rst = 1'b1;
        tick();                                           // C27
        rst = 1'b0; #1;
        sb.push_back(32'h0);
        check("rrst_req", {31'h0, imem_req}, 32'h1);
        check("rrst_addr", imem_addr, 32'h0);
        check("rrst_valid", {31'h0, id_valid}, 32'h0);
        check("rrst_instr", id_instr, NOP);
        check("rrst_pc", id_pc, 32'h0);
        check("rrst_pc4", id_pc_plus4, 32'h0);

        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        rst = 1'b1;
        tick(); tick();
        check("sb_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
